// File: rtl/cf_pipe.sv
// cf_pipe: clocked Muller-pipeline handshake controller with per-stage data latches.
// DEPTH C-element stages, each with a matched delay of DLY clock cycles.
// A stage latches its word when its C-element output makes a capture transition.
// Optional macro CF_PIPE_2PHASE_EN selects transition (2-phase) signalling, where
// both edges of c capture a word. Without the macro, the block is 4-phase
// return-to-zero and only rising edges of c capture a word.
module cf_pipe #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int DLY    = 4
) (
  input  logic              CLK,
  input  logic              MR_N,
  input  logic              Send_in,
  output logic              Ack_out,
  input  logic [DATA_W-1:0] Din,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [DATA_W-1:0] Dout,
  output logic [DEPTH-1:0]  CP
);

  localparam int CNT_W = (DLY < 1) ? 1 : $clog2(DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DLY - 1);

  logic [DEPTH-1:0]  c_q, c_d;
  logic [DEPTH-1:0]  d_q, d_d;
  logic [DEPTH-1:0]  cp_q;
  logic [DEPTH-1:0]  ev;
  logic [DEPTH-1:0]  a_s, b_s;
  logic [CNT_W-1:0]  cnt_q   [DEPTH];
  logic [CNT_W-1:0]  cnt_d   [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [DATA_W-1:0] data_src[DEPTH];

  // Neighbour wiring for the C-elements: a from upstream delay, b from inverted downstream delay.
  generate
    if (DEPTH == 1) begin : g_single
      assign a_s = Send_in;
      assign b_s = ~Ack_in;
    end else begin : g_chain
      assign a_s = {d_q[DEPTH-2:0], Send_in};
      assign b_s = {~Ack_in, ~d_q[DEPTH-1:1]};
    end
  endgenerate

  // C-element update and capture-event detection; all stages read pre-edge values.
  always_comb begin
    c_d = c_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_s[i] == b_s[i]) c_d[i] = a_s[i];
    end
`ifdef CF_PIPE_2PHASE_EN
    ev = c_d ^ c_q;
`else
    ev = c_d & ~c_q;
`endif
  end

  // Matched delay: d follows c exactly DLY cycles after c changes.
  always_comb begin
    d_d = d_q;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = '0;
      if (c_q[i] != d_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          d_d[i] = c_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Data latch next state: stage 0 loads Din, later stages load their upstream neighbour.
  always_comb begin
    data_src[0] = Din;
    for (int i = 1; i < DEPTH; i++) begin
      data_src[i] = data_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = ev[i] ? data_src[i] : data_q[i];
    end
  end

  // State registers; master reset discards every token and clears the outputs.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      c_q  <= '0;
      d_q  <= '0;
      cp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      c_q  <= c_d;
      d_q  <= d_d;
      cp_q <= ev;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign Ack_out  = d_q[0];
  assign Send_out = d_q[DEPTH-1];
  assign Dout     = data_q[DEPTH-1];
  assign CP       = cp_q;

endmodule

// File: tb/tb_cf_pipe.sv
// Testbench for cf_pipe: directed latency/back-pressure/reset scenarios plus a
// randomized producer/consumer run checked against a token-order model.
// Honours CF_PIPE_2PHASE_EN to follow the same signalling mode as the design.
module tb_cf_pipe;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int DLY     = 4;
  localparam int LAT_ACK = DLY;
  localparam int LAT_OUT = DEPTH * (DLY + 1) - 1;
  localparam int N_RND   = 24;

  logic              CLK;
  logic              MR_N;
  logic              Send_in, Ack_in;
  logic [DATA_W-1:0] Din;
  logic              Ack_out, Send_out;
  logic [DATA_W-1:0] Dout;
  logic [DEPTH-1:0]  CP;

  logic              s1_in, a1_in;
  logic [DATA_W-1:0] din1;
  logic              ack1_out, so1_out;
  logic [DATA_W-1:0] dout1;
  logic [0:0]        cp1;

  int n_chk  = 0;
  int n_fail = 0;
  int cp_last_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  cf_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DLY(DLY)) u_dut (
    .CLK(CLK), .MR_N(MR_N), .Send_in(Send_in), .Ack_out(Ack_out), .Din(Din),
    .Send_out(Send_out), .Ack_in(Ack_in), .Dout(Dout), .CP(CP)
  );

  cf_pipe #(.DATA_W(DATA_W), .DEPTH(1), .DLY(1)) u_dut1 (
    .CLK(CLK), .MR_N(MR_N), .Send_in(s1_in), .Ack_out(ack1_out), .Din(din1),
    .Send_out(so1_out), .Ack_in(a1_in), .Dout(dout1), .CP(cp1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count last-stage capture pulses (each pulse is high at exactly one rising edge).
  always @(posedge CLK) if (CP[DEPTH-1]) cp_last_cnt <= cp_last_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? Ack_out : Send_out;
  endfunction

  // Wait (bounded) until Ack_out (sel 0) or Send_out (sel 1) equals val, then check it.
  task automatic wait_val(input string tag, input int sel, input logic val, input int maxc);
    int k;
    k = 0;
    while (sig(sel) !== val && k < maxc) begin
      tick();
      k++;
    end
    chk(tag, 32'(sig(sel)), 32'(val));
  endtask

  // Send one token into an idle pipeline and measure both latencies from edge 0.
  task automatic first_token(input string tag, input logic [7:0] val);
    int k_ack, k_out, base;
    base    = cp_last_cnt;
    Din     = val;
    Send_in = 1'b1;
    tick();
    k_ack = -1;
    k_out = -1;
    for (int k = 1; k <= LAT_OUT + 10 && k_out < 0; k++) begin
      tick();
      if (k_ack < 0 && Ack_out === 1'b1) k_ack = k;
      if (k_out < 0 && Send_out === 1'b1) k_out = k;
    end
    chk({tag, "_ack_lat"}, 32'(k_ack), 32'(LAT_ACK));
    chk({tag, "_out_lat"}, 32'(k_out), 32'(LAT_OUT));
    chk({tag, "_dout"}, 32'(Dout), 32'(val));
    tick();
    chk({tag, "_cp_once"}, 32'(cp_last_cnt - base), 32'd1);
  endtask

  // Finish the handshake of the first token and return the pipeline to idle.
  task automatic ret_first(input string tag, input logic [7:0] val);
    int base;
    base = cp_last_cnt;
`ifdef CF_PIPE_2PHASE_EN
    Din     = 8'h5A;
    Send_in = 1'b0;
    Ack_in  = 1'b1;
    wait_val({tag, "_ack_tog"}, 0, 1'b0, 200);
    wait_val({tag, "_so_tog"}, 1, 1'b0, 200);
    chk({tag, "_dout2"}, 32'(Dout), 32'h5A);
    tick();
    chk({tag, "_cp_twice"}, 32'(cp_last_cnt - base), 32'd1);
    Ack_in = 1'b0;
    repeat (DLY + 2) tick();
`else
    Send_in = 1'b0;
    Ack_in  = 1'b1;
    wait_val({tag, "_ack_ret"}, 0, 1'b0, 200);
    wait_val({tag, "_so_ret"}, 1, 1'b0, 200);
    Ack_in = 1'b0;
    repeat (DLY + 2) tick();
    chk({tag, "_ret_nocp"}, 32'(cp_last_cnt - base), 32'd0);
    chk({tag, "_ret_dout"}, 32'(Dout), 32'(val));
`endif
  endtask

  initial begin
    int base;
    MR_N    = 1'b1;
    Send_in = 1'($urandom);
    Ack_in  = 1'($urandom);
    Din     = 8'($urandom);
    s1_in   = 1'($urandom);
    a1_in   = 1'($urandom);
    din1    = 8'($urandom);

    // Reset: outputs clear without a clock edge.
    #1 MR_N = 1'b0;
    #1;
    chk("rst_ack", 32'(Ack_out), 32'd0);
    chk("rst_so", 32'(Send_out), 32'd0);
    chk("rst_dout", 32'(Dout), 32'd0);
    chk("rst_cp", 32'(CP), 32'd0);
    Send_in = 1'b0; Ack_in = 1'b0; s1_in = 1'b0; a1_in = 1'b0;
    tick(); tick();
    MR_N = 1'b1;
    tick();

    // Single token latency, data and the return phase.
    first_token("tok", 8'hA5);
    ret_first("tok", 8'hA5);

`ifndef CF_PIPE_2PHASE_EN
    // Back-pressure: consumer withholds Ack_in while a second token is sent.
    base    = cp_last_cnt;
    Din     = 8'hA5;
    Send_in = 1'b1;
    wait_val("bp_ack1", 0, 1'b1, 200);
    Send_in = 1'b0;
    wait_val("bp_ack1r", 0, 1'b0, 200);
    wait_val("bp_so1", 1, 1'b1, 200);
    Din     = 8'h3C;
    Send_in = 1'b1;
    wait_val("bp_ack2", 0, 1'b1, 200);
    Send_in = 1'b0;
    wait_val("bp_ack2r", 0, 1'b0, 200);
    repeat (30) tick();
    chk("bp_dout_hold", 32'(Dout), 32'hA5);
    chk("bp_cp_hold", 32'(cp_last_cnt - base), 32'd1);
    chk("bp_so_hold", 32'(Send_out), 32'd1);
    Ack_in = 1'b1;
    wait_val("bp_so_fall", 1, 1'b0, 200);
    Ack_in = 1'b0;
    wait_val("bp_so2", 1, 1'b1, 200);
    chk("bp_dout2", 32'(Dout), 32'h3C);
    tick();
    chk("bp_cp2", 32'(cp_last_cnt - base), 32'd2);
    Ack_in = 1'b1;
    wait_val("bp_so2_fall", 1, 1'b0, 200);
    Ack_in = 1'b0;
    repeat (DLY + 2) tick();
`endif

    // Reset while a token sits in stage 1.
    Din     = 8'h77;
    Send_in = 1'b1;
    repeat (7) tick();
    MR_N = 1'b0;
    #1;
    chk("mrst_ack", 32'(Ack_out), 32'd0);
    chk("mrst_so", 32'(Send_out), 32'd0);
    chk("mrst_dout", 32'(Dout), 32'd0);
    chk("mrst_cp", 32'(CP), 32'd0);
    Send_in = 1'b0;
    tick(); tick();
    MR_N = 1'b1;
    first_token("rel", 8'h11);
    ret_first("rel", 8'h11);

    // Randomized producer/consumer traffic against an in-order token model.
    base = cp_last_cnt;
    fork
      begin
        for (int t = 0; t < N_RND; t++) begin
          repeat ($urandom_range(0, 4)) tick();
          Din = 8'($urandom);
          exp_q.push_back(Din);
`ifdef CF_PIPE_2PHASE_EN
          Send_in = ~Send_in;
          wait_val("rnd_ack", 0, Send_in, 300);
`else
          Send_in = 1'b1;
          wait_val("rnd_ack", 0, 1'b1, 300);
          Send_in = 1'b0;
          wait_val("rnd_ackr", 0, 1'b0, 300);
`endif
        end
      end
      begin
        for (int t = 0; t < N_RND; t++) begin
`ifdef CF_PIPE_2PHASE_EN
          wait_val("rnd_so", 1, ~Ack_in, 600);
`else
          wait_val("rnd_so", 1, 1'b1, 600);
`endif
          if (exp_q.size() == 0) chk("rnd_q_empty", 32'd1, 32'd0);
          else chk("rnd_dout", 32'(Dout), 32'(exp_q.pop_front()));
          repeat ($urandom_range(0, 6)) tick();
`ifdef CF_PIPE_2PHASE_EN
          Ack_in = ~Ack_in;
`else
          Ack_in = 1'b1;
          wait_val("rnd_sor", 1, 1'b0, 600);
          Ack_in = 1'b0;
`endif
        end
      end
    join
    repeat (DLY + 2) tick();
    chk("rnd_cp_total", 32'(cp_last_cnt - base), 32'(N_RND));

    // DEPTH=1, DLY=1 boundary instance.
    din1  = 8'h96;
    s1_in = 1'b1;
    tick();
    chk("d1_cp_e0", 32'(cp1), 32'd1);
    chk("d1_ack_e0", 32'(ack1_out), 32'd0);
    tick();
    chk("d1_ack_e1", 32'(ack1_out), 32'd1);
    chk("d1_so_e1", 32'(so1_out), 32'd1);
    chk("d1_dout", 32'(dout1), 32'h96);
    chk("d1_cp_e1", 32'(cp1), 32'd0);
    din1  = 8'h69;
    s1_in = 1'b0;
    a1_in = 1'b1;
    tick();
    chk("d1_sim_so_hold", 32'(so1_out), 32'd1);
`ifdef CF_PIPE_2PHASE_EN
    chk("d1_sim_cp", 32'(cp1), 32'd1);
`else
    chk("d1_sim_cp", 32'(cp1), 32'd0);
`endif
    tick();
    chk("d1_sim_so_fall", 32'(so1_out), 32'd0);
`ifdef CF_PIPE_2PHASE_EN
    chk("d1_sim_dout", 32'(dout1), 32'h69);
`else
    chk("d1_sim_dout", 32'(dout1), 32'h96);
`endif
    din1  = 8'h42;
    s1_in = 1'b1;
    a1_in = 1'b0;
    tick();
    chk("d1_tok2_cp", 32'(cp1), 32'd1);
    tick();
    chk("d1_tok2_so", 32'(so1_out), 32'd1);
    chk("d1_tok2_dout", 32'(dout1), 32'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
